div_ratio_monitor: RTL and testbench

Receive-side counterpart to the even clock dividers. It samples a divided-clock signal (e.g. div2/div4/div6) in the `clk` domain and measures high time, low time and period in `clk` cycles. It declares lock after a run of identical periods and flags ratio changes and stuck inputs. It sits next to divider outputs as an on-chip checker and frequency-ratio reporter.

---
 rtl/div_mon_pkg.sv | 16 +
 rtl/edge_detect.sv | 27 ++
 rtl/div_ratio_monitor.sv | 155 +++++++++++++++
 tb/tb_div_ratio_monitor.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_mon_pkg.sv
// div_mon_pkg: shared types and defaults for the divided-clock ratio monitor.
//   mon_state_t : measurement FSM states (IDLE, HIGH, LOW)
//   CW_DEF      : default phase-counter width
//   LOCK_N_DEF  : default number of identical periods needed for lock
package div_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } mon_state_t;

  localparam int CW_DEF     = 8;
  localparam int LOCK_N_DEF = 4;

endpackage

// File: rtl/edge_detect.sv
// edge_detect: registers a 1-bit synchronous signal and flags its edges.
//   clk, resetn : clock, synchronous active-low reset
//   d           : sampled signal
//   rise, fall  : combinational edge flags against the registered copy
// RST_VAL picks what the previous sample is assumed to be out of reset,
// which decides whether a level present at reset release counts as an edge.
module edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!resetn) d_q <= RST_VAL;
    else         d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/div_ratio_monitor.sv
// div_ratio_monitor: measures high time, low time and period of a divided
// clock sampled in the clk domain, declares lock after LOCK_N identical
// periods and flags ratio changes (while locked) and stuck inputs.
//   clk, resetn : clock, synchronous active-low reset
//   din         : divided signal under test, synchronous to clk
//   high_time   : high-phase cycles of the last complete period
//   low_time    : low-phase cycles of the last complete period
//   period      : high_time + low_time, one bit wider
//   valid       : one-cycle pulse when the three measurements update
//   locked      : LOCK_N consecutive identical periods seen
//   err         : one-cycle pulse on mismatch while locked, or on overflow
module div_ratio_monitor
  import div_mon_pkg::*;
#(
  parameter int CW     = CW_DEF,
  parameter int LOCK_N = LOCK_N_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          din,
  output logic [CW-1:0] high_time,
  output logic [CW-1:0] low_time,
  output logic [CW:0]   period,
  output logic          valid,
  output logic          locked,
  output logic          err
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [3:0]    LOCK_V  = 4'(LOCK_N);

  logic rise, fall;

  // Reset value 1: a din already high at reset release is not a rising edge,
  // so measurement never starts mid-phase.
  edge_detect #(.RST_VAL(1'b1)) u_edge (
    .clk    (clk),
    .resetn (resetn),
    .d      (din),
    .rise   (rise),
    .fall   (fall)
  );

  mon_state_t    state, state_n;
  logic [CW-1:0] hi_cnt, hi_n, lo_cnt, lo_n;
  logic [3:0]    match_cnt, match_n;
  logic [CW-1:0] ht_n, lt_n;
  logic [CW:0]   per_n;
  logic          valid_n, locked_n, err_n;
  logic          same;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      hi_cnt    <= '0;
      lo_cnt    <= '0;
      match_cnt <= '0;
      high_time <= '0;
      low_time  <= '0;
      period    <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      hi_cnt    <= hi_n;
      lo_cnt    <= lo_n;
      match_cnt <= match_n;
      high_time <= ht_n;
      low_time  <= lt_n;
      period    <= per_n;
      valid     <= valid_n;
      locked    <= locked_n;
      err       <= err_n;
    end
  end

  assign same = (hi_cnt == high_time) && (lo_cnt == low_time);

  always_comb begin
    state_n  = state;
    hi_n     = hi_cnt;
    lo_n     = lo_cnt;
    match_n  = match_cnt;
    ht_n     = high_time;
    lt_n     = low_time;
    per_n    = period;
    valid_n  = 1'b0;
    locked_n = locked;
    err_n    = 1'b0;

    case (state)
      IDLE: begin
        if (rise) begin
          state_n = HIGH;
          hi_n    = CNT_ONE;
          lo_n    = '0;
        end
      end

      // In HIGH the registered sample is always 1, so "not fall" means din=1.
      HIGH: begin
        if (fall) begin
          state_n = LOW;
          lo_n    = CNT_ONE;
        end else if (hi_cnt == CNT_MAX) begin
          // Stuck high: abandon the measurement, keep the last report.
          state_n  = IDLE;
          hi_n     = '0;
          lo_n     = '0;
          match_n  = '0;
          locked_n = 1'b0;
          err_n    = 1'b1;
        end else begin
          hi_n = hi_cnt + 1'b1;
        end
      end

      // In LOW the registered sample is always 0, so "not rise" means din=0.
      LOW: begin
        if (rise) begin
          ht_n    = hi_cnt;
          lt_n    = lo_cnt;
          per_n   = {1'b0, hi_cnt} + {1'b0, lo_cnt};
          valid_n = 1'b1;
          // match_cnt==0 marks the first period since IDLE: nothing to compare.
          if (match_cnt == '0 || !same) match_n = 4'd1;
          else if (match_cnt != LOCK_V) match_n = match_cnt + 1'b1;
          locked_n = (match_n == LOCK_V);
          err_n    = locked && !same;
          state_n  = HIGH;
          hi_n     = CNT_ONE;
          lo_n     = '0;
        end else if (lo_cnt == CNT_MAX) begin
          state_n  = IDLE;
          hi_n     = '0;
          lo_n     = '0;
          match_n  = '0;
          locked_n = 1'b0;
          err_n    = 1'b1;
        end else begin
          lo_n = lo_cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        hi_n    = '0;
        lo_n    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_div_ratio_monitor.sv
module tb_div_ratio_monitor;

  localparam int CW     = 8;
  localparam int LOCK_N = 4;
  localparam int MAXC   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          din;
  logic [CW-1:0] high_time, low_time;
  logic [CW:0]   period;
  logic          valid, locked, err;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  div_ratio_monitor #(.CW(CW), .LOCK_N(LOCK_N)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .din       (din),
    .high_time (high_time),
    .low_time  (low_time),
    .period    (period),
    .valid     (valid),
    .locked    (locked),
    .err       (err)
  );

  // ---------------- behavioural model (run lengths + period history) -------
  logic          m_prev;
  logic          m_armed;
  int            m_run, m_hilen;
  int            hq[$], lq[$];
  logic [CW-1:0] e_h, e_l;
  logic [CW:0]   e_p;
  logic          e_v, e_lk, e_e;

  task automatic model_step(input logic d, input logic r);
    logic rise_m, fall_m, was;
    int   n;
    e_v = 1'b0;
    e_e = 1'b0;
    if (!r) begin
      m_prev = 1'b1; m_armed = 1'b0; m_run = 0; m_hilen = 0;
      hq.delete(); lq.delete();
      e_h = '0; e_l = '0; e_p = '0; e_lk = 1'b0;
    end else begin
      rise_m = d && !m_prev;
      fall_m = !d && m_prev;
      if (m_armed) begin
        if (rise_m) begin
          was = e_lk;
          hq.push_back(m_hilen);
          lq.push_back(m_run);
          n = hq.size();
          e_v  = 1'b1;
          e_h  = CW'(m_hilen);
          e_l  = CW'(m_run);
          e_p  = (CW+1)'(m_hilen + m_run);
          e_lk = (n >= LOCK_N);
          for (int k = 1; k < LOCK_N; k++)
            if (n >= LOCK_N && (hq[n-1-k] != hq[n-1] || lq[n-1-k] != lq[n-1]))
              e_lk = 1'b0;
          e_e = was && (n >= 2) && (hq[n-2] != hq[n-1] || lq[n-2] != lq[n-1]);
          if (n > 16) begin
            void'(hq.pop_front());
            void'(lq.pop_front());
          end
          m_run = 1;
        end else if (fall_m) begin
          m_hilen = m_run;
          m_run   = 1;
        end else if (m_run == MAXC) begin
          e_e = 1'b1; e_lk = 1'b0; m_armed = 1'b0;
          hq.delete(); lq.delete();
        end else begin
          m_run++;
        end
      end else if (rise_m) begin
        m_armed = 1'b1;
        m_run   = 1;
      end
      m_prev = d;
    end
  endtask

  // ---------------- observed events ----------------------------------------
  int ev_h[$], ev_l[$], ev_p[$], ev_lk[$], ev_er[$], ev_cyc[$], err_cyc[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ev(input string name, input int i, input int h, input int l,
                        input int p, input int lk, input int er);
    n_cmp++;
    if (i >= ev_h.size()) begin
      n_fail++;
      $display("FAIL %s: event %0d missing (only %0d seen)", name, i, ev_h.size());
    end else if (ev_h[i] != h || ev_l[i] != l || ev_p[i] != p || ev_lk[i] != lk || ev_er[i] != er) begin
      n_fail++;
      $display("FAIL %s: event %0d got h=%0d l=%0d p=%0d lk=%0d err=%0d expected h=%0d l=%0d p=%0d lk=%0d err=%0d",
               name, i, ev_h[i], ev_l[i], ev_p[i], ev_lk[i], ev_er[i], h, l, p, lk, er);
    end
  endtask

  // ---------------- per-cycle compare process -------------------------------
  initial begin
    logic s_din, s_rst;
    forever begin
      @(posedge clk);
      s_din = din;
      s_rst = resetn;
      @(negedge clk);
      cyc++;
      model_step(s_din, s_rst);
      n_cmp++;
      if (high_time !== e_h || low_time !== e_l || period !== e_p ||
          valid !== e_v || locked !== e_lk || err !== e_e) begin
        n_fail++;
        if (n_fail < 40)
          $display("FAIL model cyc %0d: got h=%0d l=%0d p=%0d v=%b lk=%b err=%b expected h=%0d l=%0d p=%0d v=%b lk=%b err=%b",
                   cyc, high_time, low_time, period, valid, locked, err,
                   e_h, e_l, e_p, e_v, e_lk, e_e);
      end
      if (valid === 1'b1) begin
        ev_h.push_back(int'(high_time));
        ev_l.push_back(int'(low_time));
        ev_p.push_back(int'(period));
        ev_lk.push_back(int'(locked));
        ev_er.push_back(int'(err));
        ev_cyc.push_back(cyc);
      end
      if (err === 1'b1) err_cyc.push_back(cyc);
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) tick();
  endtask

  task automatic pat(input int h, input int l, input int n);
    repeat (n) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_ev();
    ev_h.delete(); ev_l.delete(); ev_p.delete(); ev_lk.delete();
    ev_er.delete(); ev_cyc.delete(); err_cyc.delete();
  endtask

  task automatic do_reset(input logic lvl);
    resetn = 1'b0;
    din    = lvl;
    repeat (3) tick();
    resetn = 1'b1;
    clear_ev();
  endtask

  initial begin
    int h, l, n;
    resetn = 1'b0;
    din    = 1'b0;

    // reset state
    do_reset(1'b0);
    settle();
    chk("reset valid", int'(valid), 0);
    chk("reset locked", int'(locked), 0);
    chk("reset period", int'(period), 0);

    // div2
    drive(1'b0, 2);
    pat(1, 1, 6);
    settle();
    chk_ev("div2 first", 0, 1, 1, 2, 0, 0);
    chk_ev("div2 third", 2, 1, 1, 2, 0, 0);
    chk_ev("div2 lock", 3, 1, 1, 2, 1, 0);
    chk("div2 err count", err_cyc.size(), 0);

    // div6 then switch to 2/2
    do_reset(1'b0);
    drive(1'b0, 2);
    pat(3, 3, 6);
    pat(2, 2, 6);
    settle();
    chk_ev("div6 first", 0, 3, 3, 6, 0, 0);
    chk_ev("div6 lock", 3, 3, 3, 6, 1, 0);
    chk_ev("switch err", 6, 2, 2, 4, 0, 1);
    chk_ev("switch 3rd", 8, 2, 2, 4, 0, 0);
    chk_ev("switch relock", 9, 2, 2, 4, 1, 0);
    chk("switch err count", err_cyc.size(), 1);

    // unequal duty, same period
    do_reset(1'b0);
    drive(1'b0, 2);
    pat(1, 5, 5);
    pat(2, 4, 2);
    drive(1'b1, 1);
    settle();
    chk_ev("duty locked", 4, 1, 5, 6, 1, 0);
    chk_ev("duty break", 5, 2, 4, 6, 0, 1);
    chk_ev("duty after", 6, 2, 4, 6, 0, 0);

    // stuck high
    do_reset(1'b0);
    drive(1'b0, 2);
    pat(3, 3, 5);
    clear_ev();
    drive(1'b1, 300);
    settle();
    chk("stuck valid count", ev_h.size(), 1);
    chk_ev("stuck closing", 0, 3, 3, 6, 1, 0);
    chk("stuck err count", err_cyc.size(), 1);
    if (err_cyc.size() == 1 && ev_cyc.size() == 1)
      chk("stuck err delay", err_cyc[0] - ev_cyc[0], MAXC);
    chk("stuck locked", int'(locked), 0);
    chk("stuck hold period", int'(period), 6);
    clear_ev();
    drive(1'b0, 3);
    pat(2, 2, 2);
    drive(1'b1, 1);
    settle();
    chk("restart count", ev_h.size(), 2);
    chk_ev("restart first", 0, 2, 2, 4, 0, 0);

    // din high at reset release
    do_reset(1'b1);
    drive(1'b1, 5);
    drive(1'b0, 3);
    drive(1'b1, 2);
    drive(1'b0, 2);
    settle();
    chk("high-release no valid", ev_h.size(), 0);
    drive(1'b1, 1);
    settle();
    chk_ev("high-release first", 0, 2, 2, 4, 0, 0);

    // reset mid-LOW while locked
    do_reset(1'b0);
    drive(1'b0, 2);
    pat(2, 2, 5);
    settle();
    chk("pre-reset locked", int'(locked), 1);
    resetn = 1'b0;
    tick();
    settle();
    chk("mid reset outs", int'({high_time, low_time, period, valid, locked, err}), 0);
    resetn = 1'b1;

    // randomized patterns, checked cycle by cycle against the model
    do_reset(1'b0);
    drive(1'b0, 2);
    repeat (80) begin
      h = $urandom_range(1, 4);
      l = $urandom_range(1, 4);
      n = $urandom_range(1, 6);
      pat(h, l, n);
      if ($urandom_range(0, 19) == 0) drive(1'($urandom_range(0, 1)), $urandom_range(250, 262));
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
